// File: rtl/motor_host_link.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// motor_host_link
// Host-side UART endpoint for the motor controller board (8N1, LSB first,
// full duplex). The TX path serialises 8-bit speed set points towards the
// controller's UART receiver; the RX path deserialises 8-bit encoder values
// coming back from the controller. The two paths share only the clock and
// reset and run completely independently.
//
// Ports
//   CLK        in   1  system clock
//   RST        in   1  synchronous reset, active-high
//   SP_VALID   in   1  set point offered this cycle
//   SP_DATA    in   8  set point byte (0 is a legal "hold previous" value)
//   SP_READY   out  1  TX path idle; byte taken when SP_VALID & SP_READY
//   TX         out  1  serial line to controller, idles high
//   RX         in   1  serial line from controller, asynchronous
//   ENC_VALID  out  1  one-cycle pulse, new encoder byte on ENC_DATA
//   ENC_DATA   out  8  last good encoder byte, held until the next good frame
//   FRAME_ERR  out  1  one-cycle pulse, received frame had a low stop bit
// -----------------------------------------------------------------------------
module motor_host_link #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SP_VALID,
  input  logic [7:0] SP_DATA,
  output logic       SP_READY,
  output logic       TX,
  input  logic       RX,
  output logic       ENC_VALID,
  output logic [7:0] ENC_DATA,
  output logic       FRAME_ERR
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  // Last count of the half-bit wait used to land RX sampling at bit centre.
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  tx_state_t         tx_state_reg, tx_state_next;
  logic [BAUD_W-1:0] tx_baud_reg, tx_baud_next;
  logic [2:0]        tx_bit_reg, tx_bit_next;
  logic [7:0]        tx_shift_reg, tx_shift_next;
  logic              tx_reg, tx_next;
  logic              sp_ready_reg, sp_ready_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state_reg <= TX_IDLE;
      tx_baud_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_reg       <= 1'b1;
      sp_ready_reg <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_baud_reg  <= tx_baud_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_reg       <= tx_next;
      sp_ready_reg <= sp_ready_next;
    end
  end

  // The line value is registered one state ahead: whatever bit the FSM moves
  // into is loaded into tx_reg on the same edge, so TX changes exactly at
  // bit boundaries with no combinational path to the pin.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_baud_next  = tx_baud_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_next       = tx_reg;
    sp_ready_next = sp_ready_reg;

    unique case (tx_state_reg)
      TX_IDLE: begin
        if (SP_VALID && sp_ready_reg) begin
          tx_state_next = TX_START;
          tx_shift_next = SP_DATA;
          tx_baud_next  = '0;
          tx_next       = 1'b0;
          sp_ready_next = 1'b0;
        end
      end
      TX_START: begin
        if (tx_baud_reg == BAUD_LAST) begin
          tx_state_next = TX_DATA;
          tx_baud_next  = '0;
          tx_bit_next   = '0;
          tx_next       = tx_shift_reg[0];
        end else begin
          tx_baud_next = tx_baud_reg + BAUD_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_baud_reg == BAUD_LAST) begin
          tx_baud_next = '0;
          if (tx_bit_reg == 3'd7) begin
            tx_state_next = TX_STOP;
            tx_next       = 1'b1;
          end else begin
            // Shift right so the next bit to send is always at index 0.
            tx_bit_next   = tx_bit_reg + 3'd1;
            tx_shift_next = {1'b0, tx_shift_reg[7:1]};
            tx_next       = tx_shift_reg[1];
          end
        end else begin
          tx_baud_next = tx_baud_reg + BAUD_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_baud_reg == BAUD_LAST) begin
          tx_state_next = TX_IDLE;
          tx_baud_next  = '0;
          sp_ready_next = 1'b1;
        end else begin
          tx_baud_next = tx_baud_reg + BAUD_W'(1);
        end
      end
      default: begin
        tx_state_next = TX_IDLE;
        tx_next       = 1'b1;
        sp_ready_next = 1'b1;
      end
    endcase
  end

  assign TX       = tx_reg;
  assign SP_READY = sp_ready_reg;

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  logic              rx_meta_reg, rx_sync_reg;
  rx_state_t         rx_state_reg, rx_state_next;
  logic [BAUD_W-1:0] rx_baud_reg, rx_baud_next;
  logic [2:0]        rx_bit_reg, rx_bit_next;
  logic [7:0]        rx_shift_reg, rx_shift_next;
  logic [7:0]        enc_data_reg, enc_data_next;
  logic              enc_valid_reg, enc_valid_next;
  logic              frame_err_reg, frame_err_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_reg   <= 1'b1;
      rx_sync_reg   <= 1'b1;
      rx_state_reg  <= RX_IDLE;
      rx_baud_reg   <= '0;
      rx_bit_reg    <= '0;
      rx_shift_reg  <= '0;
      enc_data_reg  <= '0;
      enc_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_meta_reg   <= RX;
      rx_sync_reg   <= rx_meta_reg;
      rx_state_reg  <= rx_state_next;
      rx_baud_reg   <= rx_baud_next;
      rx_bit_reg    <= rx_bit_next;
      rx_shift_reg  <= rx_shift_next;
      enc_data_reg  <= enc_data_next;
      enc_valid_reg <= enc_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    rx_state_next  = rx_state_reg;
    rx_baud_next   = rx_baud_reg;
    rx_bit_next    = rx_bit_reg;
    rx_shift_next  = rx_shift_reg;
    enc_data_next  = enc_data_reg;
    enc_valid_next = 1'b0;
    frame_err_next = 1'b0;

    unique case (rx_state_reg)
      RX_IDLE: begin
        if (!rx_sync_reg) begin
          rx_state_next = RX_START;
          rx_baud_next  = '0;
        end
      end
      RX_START: begin
        // Half a bit in: a line that is already high again was a glitch.
        if (rx_baud_reg == HALF_LAST) begin
          rx_baud_next = '0;
          rx_bit_next  = '0;
          if (rx_sync_reg) begin
            rx_state_next = RX_IDLE;
          end else begin
            rx_state_next = RX_DATA;
          end
        end else begin
          rx_baud_next = rx_baud_reg + BAUD_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_baud_reg == BAUD_LAST) begin
          rx_baud_next  = '0;
          // LSB arrives first, so shift in from the top.
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
          if (rx_bit_reg == 3'd7) begin
            rx_state_next = RX_STOP;
          end else begin
            rx_bit_next = rx_bit_reg + 3'd1;
          end
        end else begin
          rx_baud_next = rx_baud_reg + BAUD_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_baud_reg == BAUD_LAST) begin
          rx_baud_next = '0;
          if (rx_sync_reg) begin
            rx_state_next  = RX_IDLE;
            enc_data_next  = rx_shift_reg;
            enc_valid_next = 1'b1;
          end else begin
            // Park until the line recovers so a break reports only once.
            rx_state_next  = RX_WAIT_HIGH;
            frame_err_next = 1'b1;
          end
        end else begin
          rx_baud_next = rx_baud_reg + BAUD_W'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync_reg) begin
          rx_state_next = RX_IDLE;
        end
      end
      default: begin
        rx_state_next = RX_IDLE;
      end
    endcase
  end

  assign ENC_VALID = enc_valid_reg;
  assign ENC_DATA  = enc_data_reg;
  assign FRAME_ERR = frame_err_reg;

endmodule
